// File: rtl/spart_tx.sv
// spart_tx: SPART transmit path, a programmable 16x baud generator driving an 8N1 serializer.
module spart_tx #(
    parameter logic [15:0] DIV_RESET = 16'h0145
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] ioaddr,
    input  logic [7:0] divisor,
    input  logic [7:0] tx_data,
    input  logic       transmit,
    output logic       tbr,
    output logic       txd,
    output logic       baud_en,
    output logic       bit_shift
);

    localparam int unsigned DIV_W = 16;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SR_W  = 10;

    localparam logic [1:0] ADDR_DB_LOW  = 2'b10;
    localparam logic [1:0] ADDR_DB_HIGH = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_next;
    logic [DIV_W-1:0]   cnt;
    logic               div_wr;
    logic               tick;
    logic [SR_W-1:0]    sr;
    logic [CNT_W-1:0]   tc;
    logic [CNT_W-1:0]   bc;

    // Divisor byte-lane update; a write also suppresses the tick for that cycle.
    always_comb begin
        div_next = div_q;
        div_wr   = 1'b0;
        if (ioaddr == ADDR_DB_LOW) begin
            div_next[7:0] = divisor;
            div_wr        = 1'b1;
        end else if (ioaddr == ADDR_DB_HIGH) begin
            div_next[15:8] = divisor;
            div_wr         = 1'b1;
        end
    end

    // Tick when the down-counter sits at zero, never during reset or a divisor write.
    assign tick      = rst && !div_wr && (cnt == DIV_W'(0));
    assign baud_en   = tick;
    assign bit_shift = (state == SEND) && tick && (tc == CNT_W'(15));
    assign txd       = sr[0];

    // Divisor register and free-running baud down-counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= DIV_RESET;
            cnt   <= DIV_RESET;
        end else begin
            div_q <= div_next;
            if (div_wr) begin
                cnt <= div_next;
            end else if (cnt == DIV_W'(0)) begin
                cnt <= div_q;
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

    // Transmit FSM; sr idles all-ones so txd reads high whenever no frame is active.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sr    <= '1;
            tc    <= '0;
            bc    <= '0;
            tbr   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (transmit) begin
                        sr    <= {1'b1, tx_data, 1'b0};
                        tc    <= '0;
                        bc    <= '0;
                        tbr   <= 1'b0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (tick) begin
                        tc <= tc + CNT_W'(1);
                        if (tc == CNT_W'(15)) begin
                            sr <= {1'b1, sr[SR_W-1:1]};
                            bc <= bc + CNT_W'(1);
                            if (bc == CNT_W'(9)) begin
                                tbr   <= 1'b1;
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tbr   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spart_tx.sv
// tb_spart_tx: directed bench for spart_tx with a short reset divisor (tick every 5 clk).
module tb_spart_tx;

    logic       clk;
    logic       rst;
    logic [1:0] ioaddr;
    logic [7:0] divisor;
    logic [7:0] tx_data;
    logic       transmit;
    logic       tbr;
    logic       txd;
    logic       baud_en;
    logic       bit_shift;

    int n_cmp = 0;
    int n_err = 0;

    spart_tx #(.DIV_RESET(16'd4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ioaddr    (ioaddr),
        .divisor   (divisor),
        .tx_data   (tx_data),
        .transmit  (transmit),
        .tbr       (tbr),
        .txd       (txd),
        .baud_en   (baud_en),
        .bit_shift (bit_shift)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Wait (bounded) for tbr, then pulse transmit for one cycle; report txd/tbr right after the load edge.
    task automatic start_frame(input logic [7:0] d, output logic ok, output int waited,
                               output logic txd_o, output logic tbr_o);
        waited = 0;
        while (!tbr && waited < 5000) begin
            @(posedge clk); #1;
            waited++;
        end
        ok = tbr;
        txd_o = 1'bx;
        tbr_o = 1'bx;
        if (ok) begin
            tx_data  = d;
            transmit = 1'b1;
            @(posedge clk); #1;
            transmit = 1'b0;
            txd_o = txd;
            tbr_o = tbr;
        end
    endtask

    // Sample txd 7 ticks into each of 10 bits, record bit_shift spacing and tbr after the frame.
    task automatic capture_frame(input bit inject, output logic [9:0] bits, output logic ok,
                                 output logic busy_ok, output int gap_min, output int gap_max,
                                 output logic tbr_after);
        int  cyc;
        int  last;
        int  n;
        bit  seen;
        cyc = 0; last = -1; ok = 1'b1; busy_ok = 1'b1;
        gap_min = 32'h7fffffff; gap_max = 0; bits = '1;
        for (int i = 0; i < 10 && ok; i++) begin
            n = 0;
            while (n < 7 && ok) begin
                @(negedge clk); cyc++;
                if (tbr) busy_ok = 1'b0;
                if (baud_en) n++;
                if (bit_shift) begin
                    if (last >= 0) begin
                        if (cyc - last < gap_min) gap_min = cyc - last;
                        if (cyc - last > gap_max) gap_max = cyc - last;
                    end
                    last = cyc;
                end
                if (cyc > 4000) ok = 1'b0;
            end
            bits[i] = txd;
            if (inject && i == 3) begin
                tx_data  = 8'h55;
                transmit = 1'b1;
            end
            seen = 1'b0;
            while (!seen && ok) begin
                @(negedge clk); cyc++;
                if (tbr) busy_ok = 1'b0;
                if (bit_shift) begin
                    seen = 1'b1;
                    if (last >= 0) begin
                        if (cyc - last < gap_min) gap_min = cyc - last;
                        if (cyc - last > gap_max) gap_max = cyc - last;
                    end
                    last = cyc;
                end
                if (cyc > 4000) ok = 1'b0;
            end
            if (inject && i == 3) transmit = 1'b0;
        end
        tbr_after = 1'b0;
        if (ok) begin
            @(posedge clk); #1;
            tbr_after = tbr;
        end
    endtask

    task automatic test_reset();
        logic exp;
        #13;
        n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL reset_txd: got %b expected 1", txd); end
        n_cmp++; if (tbr !== 1'b1) begin n_err++; $display("FAIL reset_tbr: got %b expected 1", tbr); end
        n_cmp++; if (baud_en !== 1'b0) begin n_err++; $display("FAIL reset_baud_en: got %b expected 0", baud_en); end
        n_cmp++; if (bit_shift !== 1'b0) begin n_err++; $display("FAIL reset_bit_shift: got %b expected 0", bit_shift); end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        // Counter starts at 4: ticks in the 4th, 9th, 14th cycle after release.
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            exp = (k % 5 == 4);
            n_cmp++;
            if (baud_en !== exp) begin
                n_err++; $display("FAIL reset_tick_cycle%0d: got %b expected %b", k, baud_en, exp);
            end
        end
    endtask

    task automatic test_idle_line();
        int  w;
        bit  found;
        for (int i = 0; i < 3; i++) begin
            w = 0; found = 1'b0;
            while (!found && w < 100) begin
                @(negedge clk); w++;
                if (baud_en) found = 1'b1;
            end
            n_cmp++;
            if (!found) begin n_err++; $display("FAIL idle_tick_timeout: got none expected tick"); end
            @(posedge clk); @(posedge clk); #1;
            n_cmp++;
            if ({txd, tbr} !== 2'b11) begin
                n_err++; $display("FAIL idle_line%0d: got txd,tbr=%b expected 11", i, {txd, tbr});
            end
        end
    endtask

    task automatic test_frame_ef();
        logic ok, t, b, ok2, busy, ta;
        logic [9:0] bits;
        int w, gmin, gmax;
        start_frame(8'hEF, ok, w, t, b);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL ef_start_wait: got %b expected 1", ok); end
        n_cmp++; if ({t, b} !== 2'b00) begin n_err++; $display("FAIL ef_load_latency: got txd,tbr=%b expected 00", {t, b}); end
        capture_frame(1'b0, bits, ok2, busy, gmin, gmax, ta);
        n_cmp++; if (ok2 !== 1'b1) begin n_err++; $display("FAIL ef_capture_timeout: got %b expected 1", ok2); end
        n_cmp++; if (bits !== 10'h3DE) begin n_err++; $display("FAIL ef_bits: got %h expected 3de", bits); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ef_tbr_low: got %b expected 1", busy); end
        n_cmp++; if (gmin !== 80 || gmax !== 80) begin n_err++; $display("FAIL ef_bit_period: got %0d..%0d expected 80", gmin, gmax); end
        n_cmp++; if (ta !== 1'b1) begin n_err++; $display("FAIL ef_tbr_after: got %b expected 1", ta); end
    endtask

    task automatic test_bit_period();
        logic ok, t, b, ok2, busy, ta;
        logic [9:0] bits;
        int w, gmin, gmax, gap;
        bit found;
        // Divisor 0: no tick while the write is held, then a tick every cycle.
        @(posedge clk); #1;
        ioaddr = 2'b11; divisor = 8'h00;
        @(posedge clk); #1;
        ioaddr = 2'b10; divisor = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (baud_en !== 1'b0) begin n_err++; $display("FAIL write_cycle_tick%0d: got %b expected 0", i, baud_en); end
        end
        ioaddr = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (baud_en !== 1'b1) begin n_err++; $display("FAIL div0_tick%0d: got %b expected 1", i, baud_en); end
            @(posedge clk); #1;
        end
        ioaddr = 2'b10; divisor = 8'h03;
        @(posedge clk); #1;
        ioaddr = 2'b01;
        w = 0; found = 1'b0;
        while (!found && w < 100) begin
            @(negedge clk); w++;
            if (baud_en) found = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            gap = 0; found = 1'b0;
            while (!found && gap < 100) begin
                @(negedge clk); gap++;
                if (baud_en) found = 1'b1;
            end
            n_cmp++; if (gap !== 4) begin n_err++; $display("FAIL div3_tick_gap%0d: got %0d expected 4", i, gap); end
        end
        start_frame(8'h3C, ok, w, t, b);
        n_cmp++; if ({ok, t, b} !== 3'b100) begin n_err++; $display("FAIL p3c_load: got ok,txd,tbr=%b expected 100", {ok, t, b}); end
        capture_frame(1'b0, bits, ok2, busy, gmin, gmax, ta);
        n_cmp++; if (bits !== 10'h278) begin n_err++; $display("FAIL p3c_bits: got %h expected 278", bits); end
        n_cmp++; if (gmin !== 64 || gmax !== 64) begin n_err++; $display("FAIL p3c_bit_period: got %0d..%0d expected 64", gmin, gmax); end
        n_cmp++; if ({ok2, busy, ta} !== 3'b111) begin n_err++; $display("FAIL p3c_frame_flags: got %b expected 111", {ok2, busy, ta}); end
    endtask

    task automatic test_busy_ignore();
        logic ok, t, b, ok2, busy, ta;
        logic [9:0] bits;
        int w, gmin, gmax;
        bit idle_ok;
        start_frame(8'h84, ok, w, t, b);
        n_cmp++; if ({ok, t, b} !== 3'b100) begin n_err++; $display("FAIL busy_load: got ok,txd,tbr=%b expected 100", {ok, t, b}); end
        capture_frame(1'b1, bits, ok2, busy, gmin, gmax, ta);
        n_cmp++; if (bits !== 10'h308) begin n_err++; $display("FAIL busy_bits: got %h expected 308", bits); end
        n_cmp++; if ({ok2, busy, ta} !== 3'b111) begin n_err++; $display("FAIL busy_frame_flags: got %b expected 111", {ok2, busy, ta}); end
        idle_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!(txd === 1'b1 && tbr === 1'b1)) idle_ok = 1'b0;
        end
        n_cmp++; if (idle_ok !== 1'b1) begin n_err++; $display("FAIL busy_no_second_frame: got %b expected 1", idle_ok); end
    endtask

    task automatic test_back_to_back();
        logic ok, t, b, ok2, busy, ta;
        logic [9:0] bits;
        int w, gmin, gmax;
        start_frame(8'h00, ok, w, t, b);
        n_cmp++; if ({ok, t, b} !== 3'b100) begin n_err++; $display("FAIL b2b_load0: got ok,txd,tbr=%b expected 100", {ok, t, b}); end
        capture_frame(1'b0, bits, ok2, busy, gmin, gmax, ta);
        n_cmp++; if (bits !== 10'h200) begin n_err++; $display("FAIL b2b_bits0: got %h expected 200", bits); end
        n_cmp++; if ({ok2, busy, ta} !== 3'b111) begin n_err++; $display("FAIL b2b_flags0: got %b expected 111", {ok2, busy, ta}); end
        start_frame(8'hFF, ok, w, t, b);
        n_cmp++; if (w !== 0) begin n_err++; $display("FAIL b2b_rearm_wait: got %0d expected 0", w); end
        n_cmp++; if ({ok, t, b} !== 3'b100) begin n_err++; $display("FAIL b2b_load1: got ok,txd,tbr=%b expected 100", {ok, t, b}); end
        capture_frame(1'b0, bits, ok2, busy, gmin, gmax, ta);
        n_cmp++; if (bits !== 10'h3FE) begin n_err++; $display("FAIL b2b_bits1: got %h expected 3fe", bits); end
        n_cmp++; if ({ok2, busy, ta} !== 3'b111) begin n_err++; $display("FAIL b2b_flags1: got %b expected 111", {ok2, busy, ta}); end
    endtask

    task automatic test_reset_mid_frame();
        logic ok, t, b, ok2, busy, ta;
        logic [9:0] bits;
        int w, gmin, gmax, shifts;
        start_frame(8'h00, ok, w, t, b);
        n_cmp++; if ({ok, t, b} !== 3'b100) begin n_err++; $display("FAIL rmf_load: got ok,txd,tbr=%b expected 100", {ok, t, b}); end
        shifts = 0; w = 0;
        while (shifts < 4 && w < 2000) begin
            @(negedge clk); w++;
            if (bit_shift) shifts++;
        end
        repeat (8) @(negedge clk);
        n_cmp++; if ({txd, tbr} !== 2'b00) begin n_err++; $display("FAIL rmf_data_bit3: got txd,tbr=%b expected 00", {txd, tbr}); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if ({txd, tbr} !== 2'b11) begin n_err++; $display("FAIL rmf_async_abort: got txd,tbr=%b expected 11", {txd, tbr}); end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        start_frame(8'hA5, ok, w, t, b);
        n_cmp++; if ({ok, t, b} !== 3'b100) begin n_err++; $display("FAIL rmf_a5_load: got ok,txd,tbr=%b expected 100", {ok, t, b}); end
        capture_frame(1'b0, bits, ok2, busy, gmin, gmax, ta);
        n_cmp++; if (bits !== 10'h34A) begin n_err++; $display("FAIL rmf_a5_bits: got %h expected 34a", bits); end
        n_cmp++; if (gmin !== 80 || gmax !== 80) begin n_err++; $display("FAIL rmf_div_restored: got %0d..%0d expected 80", gmin, gmax); end
        n_cmp++; if ({ok2, busy, ta} !== 3'b111) begin n_err++; $display("FAIL rmf_a5_flags: got %b expected 111", {ok2, busy, ta}); end
    endtask

    initial begin
        rst      = 1'b0;
        ioaddr   = 2'b01;
        divisor  = 8'h00;
        tx_data  = 8'h00;
        transmit = 1'b0;
        test_reset();
        test_idle_line();
        test_frame_ef();
        test_bit_period();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spart_tx.md
# spart_tx

Transmit half of the SPART serial port: a programmable baud-rate generator feeding a UART-style 8N1 transmitter. The generator produces a one-cycle enable tick at 16× the baud rate. The transmitter frames a byte as start bit, 8 data bits LSB-first, and stop bit, and shifts it onto `txd`. It sits between the SPART bus interface (`ioaddr`, `divisor` data byte, `tx_data`, `transmit`) and the serial pin.

## Interface
- `DIV_RESET` — default 16'h0145 — divisor value loaded at reset (325: 9600 baud ×16 from 50 MHz).
- `clk` — input — 1 — system clock; all state updates on its rising edge.
- `rst` — input — 1 — reset, asynchronous, active-low.
- `ioaddr` — input — 2 — register select: 2'b00 DATA, 2'b01 STATUS, 2'b10 DB_LOW, 2'b11 DB_HIGH.
- `divisor` — input — 8 — divisor byte written when `ioaddr` selects DB_LOW or DB_HIGH.
- `tx_data` — input — 8 — byte to transmit; sampled in the cycle `transmit` is accepted.
- `transmit` — input — 1 — load strobe; one or more cycles high.
- `tbr` — output — 1 — transmit buffer ready; 1 = idle and able to accept `transmit`.
- `txd` — output — 1 — serial output line; idles high.
- `baud_en` — output — 1 — one-cycle 16× baud tick.
- `bit_shift` — output — 1 — one-cycle pulse at each bit boundary.

## Operation
- **Divisor register (16 bit)**
  - Resets to `DIV_RESET`.
  - When `ioaddr` == DB_LOW, the low byte is set to `divisor` on each clock edge.
  - When `ioaddr` == DB_HIGH, the high byte is set to `divisor` on each clock edge.
  - DATA and STATUS do not touch the register.
- **Baud counter (16 bit, down-counter)**
  - Resets to the divisor value.
  - Decrements every cycle.
  - When it reaches 0: `baud_en` = 1 for that cycle, and the counter reloads the divisor.
  - Resulting tick period is divisor+1 cycles; divisor 0 gives a tick every cycle.
  - Any divisor write reloads the counter from the new value on the next edge; no `baud_en` is generated in the write cycle.
- **Transmitter state**
  - 10-bit shift register `sr`.
  - 4-bit tick counter `tc`.
  - 4-bit bit counter `bc`.
  - Two states, IDLE and SEND.
- **IDLE**
  - `txd` = 1, `tbr` = 1.
  - `transmit` = 1 → `sr` ← {1'b1, tx_data, 1'b0}, `tc` ← 0, `bc` ← 0, go to SEND.
- **SEND**
  - `txd` = `sr[0]`, `tbr` = 0.
  - On each `baud_en`, `tc` increments.
  - On `baud_en` with `tc` == 15:
    - `bit_shift` = 1 for that cycle.
    - `sr` ← {1'b1, `sr[9:1]`}.
    - `bc` increments.
  - If `bc` was 9 at that boundary (the stop bit has completed), go to IDLE.
- `transmit` during SEND is ignored; no queuing.
- `bit_shift` is 0 in IDLE.
- The baud counter free-runs; the transmitter does not resynchronise it on a load.

## Timing
- **Reset values (while `rst` is low):**
  - `txd` = 1, `tbr` = 1.
  - `baud_en` = 0, `bit_shift` = 0.
  - State IDLE, divisor = `DIV_RESET`.
  - Asserting `rst` mid-frame aborts the frame immediately; `txd` returns high asynchronously.
- **Load latency:** `transmit` is sampled at edge N. `txd` = 0 (start bit) and `tbr` = 0 from edge N onward.
- **Bit period:** exactly 16 `baud_en` ticks = 16·(divisor+1) clk.
  - The first bit (start bit) may be shorter by up to one tick interval, because the baud counter is not aligned to the load.
- **Frame:** 10 bit periods (start, D0..D7, stop). `tbr` rises on the edge after the 10th `bit_shift`.
- **Re-arm:** a new `transmit` is accepted in the cycle after `tbr` rises. Back-to-back frames have no extra idle bits.
- **Simultaneous events:**
  - `transmit` together with a divisor write is legal; both take effect.
  - `baud_en` in the load cycle does not advance `tc`.

## Test plan
- **Idle line.** Reset and release, hold `transmit` = 0 for ≥3 `baud_en` ticks → `txd` = 1 and `tbr` = 1 two clocks after every tick.
- **Frame 0xEF.** Pulse `transmit` for one cycle with `tx_data` = 8'hEF. Sample `txd` 7 ticks into each bit → 0,1,1,1,1,0,1,1,1,1 (start, LSB-first data, stop). Then `tbr` = 1 after the 10th `bit_shift`.
- **Bit period.**
  - Write DB_LOW = 8'h03 and DB_HIGH = 8'h00.
  - Expect `baud_en` every 4 clk.
  - Expect `bit_shift` pulses 64 clk apart after the first bit.
- **Busy ignore.** Send 8'h84, then assert `transmit` with 8'h55 mid-frame → the frame stays 0,0,0,1,0,0,0,0,1,1. No second frame starts until `tbr` is high and `transmit` is pulsed again.
- **Back-to-back.** Load 8'h00, then 8'hFF as soon as `tbr` = 1 → the stop bit of the first frame is followed directly by the start bit of the second, and both frames are correct.
- **Reset mid-frame.** Pull `rst` low during data bit 3 → `txd` = 1 and `tbr` = 1 immediately. After release, a new transmit of 8'hA5 frames correctly.
